// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-side bundle between the raster timing generator and the renderer.
interface vga_timing_gen_if #(
    parameter int X_W     = 10,
    parameter int Y_W     = 10,
    parameter int COLOR_W = 1
);
    logic [COLOR_W-1:0] i_Video;
    logic [COLOR_W-1:0] o_Video;
    logic [X_W-1:0]     o_X;
    logic [Y_W-1:0]     o_Y;
    logic               o_LineStart;
    logic               o_FrameStart;
    logic               o_HSync;
    logic               o_VSync;
    logic               o_HBlank;
    logic               o_VBlank;
    logic               o_Active;
    modport master (
        input  i_Video,
        output o_Video, o_X, o_Y, o_LineStart, o_FrameStart,
        output o_HSync, o_VSync, o_HBlank, o_VBlank, o_Active
    );
    modport slave (
        output i_Video,
        input  o_Video, o_X, o_Y, o_LineStart, o_FrameStart,
        input  o_HSync, o_VSync, o_HBlank, o_VBlank, o_Active
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster counter with sync/blank decode and a delay line
// that keeps the flags aligned with a pipelined pixel source.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int PIPE_DELAY = 0,
    parameter int COLOR_W    = 1
) (
    input logic              i_Clk,
    input logic              i_Reset_n,
    input logic              i_Enable,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);
    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] HB0    = XW'(H_VISIBLE);
    localparam logic [XW-1:0] HS0    = XW'(H_VISIBLE + H_FRONT);
    localparam logic [XW-1:0] HS1    = XW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] VB0    = YW'(V_VISIBLE);
    localparam logic [YW-1:0] VS0    = YW'(V_VISIBLE + V_FRONT);
    localparam logic [YW-1:0] VS1    = YW'(V_VISIBLE + V_FRONT + V_SYNC);
    // flag word {hsync level, vsync level, hblank, vblank, active}
    localparam logic [4:0] FLAGS_RST = {~HSYNC_POL, ~VSYNC_POL, 3'b110};

    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic          hb, vb;
    logic [4:0]    flags_nxt;
    logic [4:0]    pipe [0:PIPE_DELAY];

    always_comb begin
        x_nxt     = (x == X_LAST) ? '0 : x + XW'(1);
        y_nxt     = (x != X_LAST) ? y : (y == Y_LAST) ? '0 : y + YW'(1);
        hb        = x_nxt >= HB0;
        vb        = y_nxt >= VB0;
        flags_nxt = {(x_nxt >= HS0 && x_nxt < HS1) ? HSYNC_POL : ~HSYNC_POL,
                     (y_nxt >= VS0 && y_nxt < VS1) ? VSYNC_POL : ~VSYNC_POL,
                     hb, vb, !hb && !vb};
    end

    // pipe[0] describes the count registered alongside it; later stages add latency
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            x <= X_LAST;
            y <= Y_LAST;
            for (int i = 0; i <= PIPE_DELAY; i++) pipe[i] <= FLAGS_RST;
        end else if (i_Enable) begin
            x       <= x_nxt;
            y       <= y_nxt;
            pipe[0] <= flags_nxt;
            for (int i = 1; i <= PIPE_DELAY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.o_X          = x;
    assign bus.o_Y          = y;
    assign bus.o_LineStart  = x == '0;
    assign bus.o_FrameStart = x == '0 && y == '0;
    assign bus.o_HSync      = pipe[PIPE_DELAY][4];
    assign bus.o_VSync      = pipe[PIPE_DELAY][3];
    assign bus.o_HBlank     = pipe[PIPE_DELAY][2];
    assign bus.o_VBlank     = pipe[PIPE_DELAY][1];
    assign bus.o_Active     = pipe[PIPE_DELAY][0];
    assign bus.o_Video      = {COLOR_W{pipe[PIPE_DELAY][0]}} & bus.i_Video;
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. Replaces the fixed 640x480 counter block with:
- configurable porch, sync and visible sizes;
- selectable sync polarity;
- a pixel clock-enable input;
- zero-based pixel coordinates and line/frame strobes;
- a configurable delay line that keeps sync and blank aligned with a pipelined pixel source.

It sits between the pixel-clock domain and the game/ball renderer, which reads o_X/o_Y and returns colour on i_Video.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of o_HSync (0 = active-low)
- VSYNC_POL, 0, active level of o_VSync
- PIPE_DELAY, 0, renderer latency in enabled ticks, range 0..15
- COLOR_W, 1, width of i_Video/o_Video

Ports (clock, reset, then the rest):
- i_Clk  in  1  system clock, rising edge only
- i_Reset_n  in  1  asynchronous active-low reset
- i_Enable  in  1  pixel tick; all state advances only on i_Clk rising edges with i_Enable=1
- i_Video  in  COLOR_W  renderer colour, valid PIPE_DELAY ticks after o_X/o_Y
- o_X  out  clog2(H_TOTAL)  current column
- o_Y  out  clog2(V_TOTAL)  current line
- o_LineStart  out  1  high while o_X==0
- o_FrameStart  out  1  high while o_X==0 and o_Y==0
- o_HSync, o_VSync  out  1  sync outputs, delayed by PIPE_DELAY
- o_HBlank, o_VBlank  out  1  blank flags, delayed by PIPE_DELAY
- o_Active  out  1  visible-area flag, delayed by PIPE_DELAY
- o_Video  out  COLOR_W  i_Video when o_Active, else 0 (combinational AND)

## Operation
- Derived totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- All sizes must be ≥1. Violations are a parameter error; the bench does not exercise them.
- Horizontal counter x runs 0..H_TOTAL-1 and wraps to 0.
- Vertical counter y increments only on an x wrap, runs 0..V_TOTAL-1 and wraps to 0 together with x.
- Decode, evaluated on the registered count:
  - HBlank = x ≥ H_VISIBLE.
  - HSync active = H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC.
  - VBlank and VSync use the same form on y.
  - Active = !HBlank && !VBlank.
  - Sync output level = active ? POL : !POL.
- Flags are computed from the next count and registered with the counters, so at PIPE_DELAY=0 they describe the same (o_X, o_Y) on the same cycle.
- Delay line: PIPE_DELAY shift stages for {HSync, VSync, HBlank, VBlank, Active}, shifting only on enabled ticks. o_LineStart and o_FrameStart are never delayed.
- With i_Enable=0, every register holds. Strobes remain asserted; consumers must qualify them with i_Enable.
- Reset (async assert, value held while low):
  - o_X = H_TOTAL-1, o_Y = V_TOTAL-1.
  - Strobes 0, o_HBlank = o_VBlank = 1, o_Active = 0, syncs at inactive level (!POL).
  - Every delay stage loads the same blank/inactive values. o_Video = 0.
- Because reset starts at the last back-porch pixel, the first enabled tick after release yields o_X=0, o_Y=0, o_FrameStart=1, o_LineStart=1, and undelayed Active=1.
- Reset asserted mid-frame: all outputs reach their reset values immediately, with no wait for a clock edge.

## Timing
- Counter latency: 1 enabled tick from count to o_X/o_Y.
- Delayed flags lag o_X/o_Y by exactly PIPE_DELAY enabled ticks.
- o_Video has zero-cycle latency from i_Video.
- Line period is H_TOTAL enabled ticks. Frame period is H_TOTAL·V_TOTAL ticks (420000 at defaults).
- Vertical transitions occur on the tick where x wraps to 0, so VSync and VBlank edges coincide with o_LineStart.
- Removing reset synchronously to i_Clk is the integrator's responsibility.

## Test plan
- Reset, then one enabled tick: (799,524) → (0,0); o_FrameStart=1, o_LineStart=1; o_Active=1; both syncs high (POL=0).
- Defaults with i_Enable tied high: o_HSync low exactly for x=656..751 (96 ticks); o_HBlank rises at x=640; line period 800 clocks.
- Frame check: o_VSync low for y=490..491 (1600 ticks). Next o_FrameStart occurs 420000 ticks after the previous one. No x/y glitch at the (799,524) wrap.
- i_Enable pattern 1,0,1,0: outputs advance every second clock; o_LineStart stays high for 2 clocks; totals double in clocks, not in ticks.
- PIPE_DELAY=3, i_Video=1 constant: o_Active and o_Video rise 3 ticks after o_X returns to 0 and fall 3 ticks after o_X=640; o_Video stays 0 outside.
- Small config (H 4/1/2/1, V 3/1/1/1, HSYNC_POL=1): o_HSync high for x=5..6. Reset asserted at (2,1) → immediate reset values; release → frame restarts at (0,0).
